// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write_en,
  input  logic [DW-1:0] mem_data,
  output logic          busy
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_q, owner_d;  // 1 = data, 0 = fetch
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          grant_data;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    busy_d      = busy_q;
    grant_data  = d_req && (!if_req || (starve_q < SW'(STARVE_MAX)));

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          if (grant_data) begin
            owner_d  = 1'b1;
            addr_d   = d_addr;
            we_d     = d_we;
            wdata_d  = d_wdata;
            if (if_req) begin
              starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
            end else begin
              starve_d = '0;
            end
          end else begin
            owner_d  = 1'b0;
            addr_d   = if_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
          end
          mem_addr_d  = addr_d;
          mem_wdata_d = wdata_d;
          mem_we_d    = we_d;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CW'(MEM_LAT - 1)) begin
          if (owner_q) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = mem_data;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_data;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack         = if_ack_q;
  assign d_ack          = d_ack_q;
  assign if_rdata       = if_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_write_en   = mem_we_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 and MEM_LAT=3 instances share the request inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic        if_ack1, d_ack1, mem_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_data1;
  logic        if_ack3, d_ack3, mem_we3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_data3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Memory contents: 0x100 holds 0xDEADBEEF, any other word is (addr ^ 0x5A5A0000) + 0x11
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A0000) + 32'h11);
  endfunction

  assign mem_data1 = mem_model(mem_addr1);
  assign mem_data3 = mem_model(mem_addr3);

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_addr(mem_addr1), .mem_write_data(mem_wdata1), .mem_write_en(mem_we1),
    .mem_data(mem_data1), .busy(busy1)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_write_data(mem_wdata3), .mem_write_en(mem_we3),
    .mem_data(mem_data3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    reset = 1'b0;
    #2;
    chk("rst_busy", busy1, 1'b0);
    chk("rst_mem_addr", mem_addr1, 32'h0);
    chk("rst_acks", {if_ack1, d_ack1, if_ack3, d_ack3}, 4'b0);
    chk("rst_rdata", if_rdata1 | d_rdata1, 32'h0);
    step(1);
    reset = 1'b1;

    // Single fetch, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h100;
    step(1);
    chk("f_c1_addr", mem_addr1, 32'h100);
    chk("f_c1_busy", busy1, 1'b1);
    chk("f_c1_we", mem_we1, 1'b0);
    chk("f_c1_ack", if_ack1, 1'b0);
    step(1);
    chk("f_c2_ack", if_ack1, 1'b1);
    chk("f_c2_rdata", if_rdata1, 32'hDEADBEEF);
    chk("f_c2_we", mem_we1, 1'b0);
    chk("f_c2_dack", d_ack1, 1'b0);
    if_req = 1'b0;
    step(1);
    chk("f_c3_ack", if_ack1, 1'b0);
    chk("f_c3_idle_addr", mem_addr1, 32'h0);
    chk("f_c3_busy", busy1, 1'b0);
    chk("f_c3_rdata_hold", if_rdata1, 32'hDEADBEEF);

    // Load then store, MEM_LAT=1
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    step(2);
    chk("ld_ack", d_ack1, 1'b1);
    chk("ld_rdata", d_rdata1, 32'h5A5A0031);
    d_req = 1'b0;
    step(1);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    step(1);
    chk("st_c1_we", mem_we1, 1'b1);
    chk("st_c1_addr", mem_addr1, 32'h40);
    chk("st_c1_wdata", mem_wdata1, 32'h12345678);
    step(1);
    chk("st_c2_we", mem_we1, 1'b0);
    chk("st_c2_ack", d_ack1, 1'b1);
    chk("st_c2_rdata_kept", d_rdata1, 32'h5A5A0031);
    d_req = 1'b0;
    step(1);
    chk("st_c3_we", mem_we1, 1'b0);
    chk("st_c3_ack", d_ack1, 1'b0);

    // Simultaneous requests: data first, fetch ack at cycle 5
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    step(1);
    chk("sim_c1_addr", mem_addr1, 32'h44);
    step(1);
    chk("sim_c2_acks", {if_ack1, d_ack1}, 2'b01);
    chk("sim_c2_drdata", d_rdata1, 32'h5A5A0055);
    d_req = 1'b0;
    step(2);
    chk("sim_c4_addr", mem_addr1, 32'h100);
    chk("sim_c4_acks", {if_ack1, d_ack1}, 2'b00);
    step(1);
    chk("sim_c5_acks", {if_ack1, d_ack1}, 2'b10);
    chk("sim_c5_irdata", if_rdata1, 32'hDEADBEEF);
    if_req = 1'b0;
    step(1);

    // Starvation guard: D,D,D,D,F,D with both requests held
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk($sformatf("stv_addr_%0d", k), mem_addr1, (k == 4) ? 32'h100 : 32'h44);
      step(1);
      chk($sformatf("stv_acks_%0d", k), {if_ack1, d_ack1}, (k == 4) ? 2'b10 : 2'b01);
      if (k == 4) if_req = 1'b0;
      if (k == 5) d_req = 1'b0;
      step(1);
    end

    // MEM_LAT=3 load
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    for (int c = 1; c <= 3; c++) begin
      step(1);
      chk($sformatf("l3_addr_c%0d", c), mem_addr3, 32'h8);
      chk($sformatf("l3_busy_c%0d", c), busy3, 1'b1);
      chk($sformatf("l3_ack_c%0d", c), d_ack3, 1'b0);
    end
    step(1);
    chk("l3_c4_ack", d_ack3, 1'b1);
    chk("l3_c4_busy", busy3, 1'b1);
    chk("l3_c4_rdata", d_rdata3, 32'h5A5A0019);
    d_req = 1'b0;
    step(1);
    chk("l3_c5_busy", busy3, 1'b0);
    chk("l3_c5_addr", mem_addr3, 32'h0);
    chk("l3_c5_ack", d_ack3, 1'b0);

    // Reset in the middle of a MEM_LAT=3 store
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
    step(1);
    chk("ra_c1_we", mem_we3, 1'b1);
    reset = 1'b0;
    #2;
    chk("ra_now_we", mem_we3, 1'b0);
    chk("ra_now_addr", mem_addr3, 32'h0);
    chk("ra_now_wdata", mem_wdata3, 32'h0);
    chk("ra_now_busy", busy3, 1'b0);
    step(1);
    chk("ra_held_ack", d_ack3, 1'b0);
    reset = 1'b1;
    step(1);
    chk("ra_re_we", mem_we3, 1'b1);
    chk("ra_re_addr", mem_addr3, 32'h40);
    step(1);
    chk("ra_re_c2_we", mem_we3, 1'b0);
    step(2);
    chk("ra_re_ack", d_ack3, 1'b1);
    d_req = 1'b0;
    step(1);
    chk("ra_re_done", {d_ack3, busy3}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (if_*) and load/store data access (d_*).
- Sits between the decoder's fetch and memory stages and the memory module.
- Drives mem_addr, mem_write_data and mem_write_en, and returns mem_data to the granted requester.
- Fixed data-over-fetch priority with a starvation guard so fetch always progresses.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles the memory port is held per access (>=1).
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  AW  fetch address; stable while if_req high.
- if_ack  output  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  output  DW  fetched word.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load; stable while d_req high.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_ack  output  1  one-cycle pulse; d_rdata valid this cycle (loads).
- d_rdata  output  DW  loaded word.
- mem_addr  output  AW  memory address.
- mem_write_data  output  DW  memory write data.
- mem_write_en  output  1  memory write strobe.
- mem_data  input  DW  memory read data, valid at the last ACCESS cycle.
- busy  output  1  high in ACCESS or RESP.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; all outputs = 0.
  - starvation counter = 0; latched request cleared.
  - Takes effect immediately, including mid-ACCESS or mid-RESP.
  - An aborted transaction produces no ack; the requester must re-request.
- States:
  - IDLE: samples if_req and d_req at each rising edge.
  - ACCESS: holds the memory port for MEM_LAT cycles; cycle counter runs 0..MEM_LAT-1.
  - RESP: one cycle, ack pulse.
- IDLE grant rule (evaluated at the edge):
  - Only one request: grant it.
  - Both requests, starve_cnt < STARVE_MAX: grant data.
  - Both requests, starve_cnt == STARVE_MAX: grant fetch.
  - On grant, latch owner, addr, we (fetch forces we=0) and wdata; go to ACCESS with cnt=0.
- Starvation counter:
  - Increments on each data grant made while if_req is high; saturates at STARVE_MAX.
  - Clears on every fetch grant.
  - Clears on a data grant made while if_req is low.
- ACCESS:
  - mem_addr and mem_write_data drive the latched values.
  - mem_write_en = 1 only in the cnt=0 cycle, and only if latched we=1: exactly one write strobe per store.
  - At the edge ending cnt=MEM_LAT-1: capture mem_data into the owner's rdata register (loads and fetches only); go to RESP.
- RESP:
  - Owner's ack = 1 for exactly this cycle.
  - mem_addr still holds the latched address; mem_write_en = 0.
  - Go to IDLE; no request is sampled in RESP.
- Requester rule:
  - Drop req, or present the next request, at the edge where ack is sampled.
  - req high in the IDLE cycle after RESP is a new request.
- Latency: req high in IDLE cycle 0 -> ack in cycle MEM_LAT+1. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Data retention:
  - if_rdata and d_rdata hold their last value until that requester's next read completes.
  - d_rdata is not updated by stores.
- Idle outputs: in IDLE, mem_addr = 0, mem_write_data = 0, mem_write_en = 0.
- Ack timing: if_ack and d_ack are never high in the same cycle.
- Request changes: a req deasserted during ACCESS does not cancel the transaction; the ack is still issued.

Test Plan:
- Single fetch, MEM_LAT=1: if_req=1, if_addr=0x100, memory returns 0xDEADBEEF -> mem_addr=0x100 in cycle 1; if_ack=1 with if_rdata=0xDEADBEEF in cycle 2; mem_write_en never high.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_write_en high exactly one cycle (cycle 1) with those values; d_ack in cycle 2; d_rdata unchanged.
- Simultaneous requests: if_req=1 and d_req=1 from reset -> data is granted first; fetch ack follows at cycle 2+(MEM_LAT+2).
- Starvation, STARVE_MAX=4: d_req continuously high and if_req high -> grants D,D,D,D,F,D,...; the fetch ack occurs within 5 transactions.
- MEM_LAT=3 load: d_addr=0x8 -> mem_addr held for 3 cycles; d_ack in cycle 4; busy high in cycles 1-4.
- Reset mid-ACCESS: assert reset low in cycle 1 of a store with MEM_LAT=3 -> all outputs 0 immediately, no ack, state IDLE; after release, a held d_req is re-granted and completes normally.
